// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit source and the detector benches:
// state encoding, default word/rate constants and a clog2 helper.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Counters never shrink below one bit, even when the terminal value is 0.
  function automatic int count_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/serial_bit_source_divider.sv
// Bit-period divider: counts 0..DIV-1 while running and strobes tick on the
// terminal count, so each serial bit lasts exactly DIV clocks.
module bit_period_divider
  import serial_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = count_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Held at zero while idle so a fresh word always starts a full bit period.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (restart || !run || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source feeding the serial sequence detectors.
// Define SERIAL_BIT_SOURCE_LSB_FIRST_EN to shift words out LSB first.
module serial_bit_source
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = count_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             last_bit;
  logic             accept;
  logic             shifting;

  assign shifting = (state == SHIFT);

  bit_period_divider #(
    .DIV(DIV)
  ) u_divider (
    .CLK    (CLK),
    .RESET  (RESET),
    .run    (shifting),
    .restart(accept),
    .tick   (tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // The last-bit cycle doubles as an accept window so words can chain gap-free.
  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    bit_valid  = 1'b0;
    last_bit   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        accept     = load_valid;
        if (load_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        bit_valid  = tick;
        last_bit   = tick && (bit_cnt == LAST_BIT);
        done       = last_bit;
        load_ready = last_bit;
        accept     = last_bit && load_valid;
        if (last_bit && !load_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SERIAL_BIT_SOURCE_LSB_FIRST_EN
  assign shifted = {1'b0, shreg[WIDTH-1:1]};
  assign bit_out = shifting & shreg[0];
`else
  assign shifted = {shreg[WIDTH-2:0], 1'b0};
  assign bit_out = shifting & shreg[WIDTH-1];
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else if (tick) begin
      shreg   <= shifted;
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench: two sources (DIV=1 and DIV=3) compared each cycle
// against a bit-position reference model, plus a bench-side 11001 detector.
module tb_serial_bit_source;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RESET;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       valid_v;
  logic [1:0]       ready_v;
  logic [1:0]       bit_v;
  logic [1:0]       strobe_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;

  int checks;
  int errors;
  int cyc;

  int               m_div  [2];
  int               m_k    [2];
  logic             m_act  [2];
  logic [WIDTH-1:0] m_word [2];

  logic [4:0] hist;
  int         det_count;
  int         det_cycle;

  serial_bit_source #(.WIDTH(WIDTH), .DIV(1)) u_src1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .load_data (data0),
    .load_valid(valid_v[0]),
    .load_ready(ready_v[0]),
    .bit_out   (bit_v[0]),
    .bit_valid (strobe_v[0]),
    .busy      (busy_v[0]),
    .done      (done_v[0])
  );

  serial_bit_source #(.WIDTH(WIDTH), .DIV(3)) u_src3 (
    .CLK       (CLK),
    .RESET     (RESET),
    .load_data (data1),
    .load_valid(valid_v[1]),
    .load_ready(ready_v[1]),
    .bit_out   (bit_v[1]),
    .bit_valid (strobe_v[1]),
    .busy      (busy_v[1]),
    .done      (done_v[1])
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic modelBit(input logic [WIDTH-1:0] w, input int idx);
`ifdef SERIAL_BIT_SOURCE_LSB_FIRST_EN
    return w[idx];
`else
    return w[WIDTH-1-idx];
`endif
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_k[i]   = 0;
    end
  endtask

  task automatic checkIdle(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_ready_u%0d", tag, i), 32'(ready_v[i]), 32'd1);
      checkOutput($sformatf("%s_bit_u%0d", tag, i), 32'(bit_v[i]), 32'd0);
      checkOutput($sformatf("%s_valid_u%0d", tag, i), 32'(strobe_v[i]), 32'd0);
      checkOutput($sformatf("%s_busy_u%0d", tag, i), 32'(busy_v[i]), 32'd0);
      checkOutput($sformatf("%s_done_u%0d", tag, i), 32'(done_v[i]), 32'd0);
    end
  endtask

  // Called just after a falling edge: drive inputs, check this cycle, step to next.
  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] d0,
                               input logic v1, input logic [WIDTH-1:0] d1);
    logic e_bit, e_valid, e_done, e_ready, e_busy, v;
    logic [WIDTH-1:0] d;
    int idx;
    valid_v[0] = v0;
    data0      = d0;
    valid_v[1] = v1;
    data1      = d1;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_act[i]) begin
        idx     = (m_k[i] - 1) / m_div[i];
        e_bit   = modelBit(m_word[i], idx);
        e_valid = (m_k[i] % m_div[i]) == 0;
        e_done  = (m_k[i] == WIDTH * m_div[i]);
        e_ready = e_done;
        e_busy  = 1'b1;
      end else begin
        e_bit   = 1'b0;
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_ready = 1'b1;
        e_busy  = 1'b0;
      end
      checkOutput($sformatf("bit_u%0d", i), 32'(bit_v[i]), 32'(e_bit));
      checkOutput($sformatf("bit_valid_u%0d", i), 32'(strobe_v[i]), 32'(e_valid));
      checkOutput($sformatf("done_u%0d", i), 32'(done_v[i]), 32'(e_done));
      checkOutput($sformatf("load_ready_u%0d", i), 32'(ready_v[i]), 32'(e_ready));
      checkOutput($sformatf("busy_u%0d", i), 32'(busy_v[i]), 32'(e_busy));
      v = (i == 0) ? v0 : v1;
      d = (i == 0) ? d0 : d1;
      if (v && e_ready) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 1;
        m_word[i] = d;
      end else if (m_act[i]) begin
        if (e_done) begin
          m_act[i] = 1'b0;
          m_k[i]   = 0;
        end else begin
          m_k[i] = m_k[i] + 1;
        end
      end
    end
    if (strobe_v[0]) begin
      hist = {hist[3:0], bit_v[0]};
      if (hist == 5'b11001) begin
        det_count++;
        det_cycle = cyc;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    int acc_cyc;
    logic [WIDTH-1:0] first_word;
    CLK     = 1'b0;
    RESET   = 1'b1;
    valid_v = '0;
    data0   = '0;
    data1   = '0;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    hist    = '0;
    det_count = 0;
    det_cycle = 0;
    m_div[0] = 1;
    m_div[1] = 3;
    resetModel();

    #2;
    checkIdle("reset");
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

`ifdef SERIAL_BIT_SOURCE_LSB_FIRST_EN
    first_word = 8'b0001_0011;
`else
    first_word = 8'b1100_1000;
`endif
    // Basic stream into the detector.
    hist    = '0;
    acc_cyc = cyc;
    applyStimulus(1'b1, first_word, 1'b0, '0);
    idleCycles(10);
    checkOutput("detector_count", 32'(det_count), 32'd1);
    checkOutput("detector_cycle", 32'(det_cycle - acc_cyc), 32'd5);

    // Back-to-back: second word held valid while the first is still shifting.
    applyStimulus(1'b1, 8'hC8, 1'b0, '0);
    for (int c = 1; c <= 8; c++) applyStimulus(1'b1, 8'hA5, 1'b0, '0);
    idleCycles(10);

    // Divided rate on the DIV=3 source.
    applyStimulus(1'b0, '0, 1'b1, 8'hC8);
    idleCycles(27);

    // Load attempt while busy must be ignored.
    applyStimulus(1'b1, 8'hFF, 1'b0, '0);
    idleCycles(2);
    applyStimulus(1'b1, 8'h00, 1'b0, '0);
    idleCycles(8);

    // Reset mid-word on the divided source.
    applyStimulus(1'b0, '0, 1'b1, 8'hFF);
    idleCycles(4);
    #2;
    RESET = 1'b1;
    #1;
    checkIdle("midreset");
    resetModel();
    @(negedge CLK);
    RESET = 1'b0;
    idleCycles(30);

    // Randomised traffic on both sources.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom));
    end
    idleCycles(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial bit stream generator that sits directly upstream of the team's serial sequence detectors (e.g. the 11001 Mealy detector).
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time on bit_out.
- Drives the detector's single-bit serial input. bit_valid serves as a bit strobe or clock enable when DIV>1 (slow on-board waveforms).

Parameters:
- WIDTH, 8, bits per word; legal 2..32.
- DIV, 1, CLK cycles per serial bit; legal 1..1024. DIV=1 gives one bit per CLK, for direct connection to a detector clocked by CLK.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- load_data  in  WIDTH  word to serialise.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block can accept a word this cycle.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  one-cycle strobe in the last CLK of each bit period.
- busy  out  1  word being shifted.
- done  out  1  one-cycle pulse in the last CLK of the last bit of a word.

Behaviour:
- Reset: RESET is asynchronous, active-high; clock is CLK. All state registers clear immediately on RESET. Outputs on reset: state=IDLE, load_ready=1, bit_out=0, bit_valid=0, busy=0, done=0, shift register=0, bit counter=0, divider counter=0.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready. load_data is captured into the shift register. load_valid while load_ready=0 is ignored, with no queueing.
- State IDLE:
  - load_ready=1, busy=0, bit_out=0.
  - Idle output is 0 so the downstream detector sits in its reset state and cannot false-match.
  - On accept, go to SHIFT.
- State SHIFT:
  - busy=1.
  - bit_out = shift register MSB, registered, so it changes only on a CLK edge.
  - The divider counts 0..DIV-1. bit_valid=1 when divider==DIV-1.
  - At divider==DIV-1: shift left by one, increment the bit counter, reset the divider.
- Latency: the first bit appears on bit_out in the cycle after the accepting edge. Each bit is held exactly DIV cycles. A word occupies WIDTH*DIV cycles.
- Last bit (bit counter==WIDTH-1 and divider==DIV-1):
  - done=1 and load_ready=1 in that same cycle.
  - If load_valid=1 there, the new word loads and its MSB follows with no gap cycle; state stays SHIFT.
  - Otherwise go to IDLE and bit_out returns to 0 the next cycle.
- load_ready=0 in SHIFT except in the last-bit cycle.
- DIV=1: the divider is constant 0 and bit_valid=1 every SHIFT cycle.
- Counter widths:
  - divider: max(1, clog2(DIV)) bits.
  - bit counter: max(1, clog2(WIDTH)) bits.
  - No wrap beyond the terminal value.
- Reset mid-word: the word is abandoned. bit_out=0 asynchronously and no done pulse is produced.
- Unused state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro SERIAL_BIT_SOURCE_LSB_FIRST_EN.
- Defined: bits shift out LSB first (shift right, bit_out = register bit 0).
- Undefined: MSB first as above. All timing is identical in both cases.

Decomposition:
- Shared package/include serial_pkg:
  - state encodings IDLE=1'b0, SHIFT=1'b1;
  - clog2 constant function;
  - default WIDTH/DIV constants, shared with the detector benches.
- One natural sub-module, bit_period_divider:
  - parameter DIV; inputs CLK, RESET, run, restart;
  - output tick (divider==DIV-1).
- The top module holds the FSM, shift register and bit counter.

Test Plan:
- Basic stream into the detector:
  - Stimulus: DIV=1, load 8'b11001000, then load_valid=0.
  - Required: bit_out = 1,1,0,0,1,0,0,0 on cycles 1..8 after accept.
  - Required: bit_valid high on all 8 cycles; done on cycle 8; downstream mealy detector out=1 on cycle 5 only; bit_out=0 from cycle 9.
- Back-to-back, no gap:
  - Stimulus: DIV=1, 8'hC8, then 8'hA5 held valid.
  - Required: second word accepted on cycle 8; cycles 9..16 show 1,0,1,0,0,1,0,1 with busy never dropping; done on cycles 8 and 16.
- Divided rate:
  - Stimulus: DIV=3, load 8'hC8.
  - Required: each bit held 3 cycles and bit_valid on every third cycle; done at cycle 24; load_ready low on cycles 1..23.
- Ignored load while busy:
  - Stimulus: DIV=1, load 8'hFF; assert load_valid with 8'h00 on cycle 3.
  - Required: output stays eight 1s and 8'h00 is never shifted.
- Reset mid-word:
  - Stimulus: DIV=2, load 8'hFF; assert RESET between edges in cycle 5.
  - Required: bit_out, busy, done drop to 0 immediately, load_ready=1, and no done pulse.
- LSB-first build (SERIAL_BIT_SOURCE_LSB_FIRST_EN defined):
  - Stimulus: DIV=1, load 8'b00010011.
  - Required: bit_out = 1,1,0,0,1,0,0,0 and the detector fires on cycle 5.
